host_mem_arbiter: RTL and testbench
===================================

HOST_MEM_ARBITER -- requirements
Module: host_mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LINES, default 128, number of 512-bit lines per accelerator transfer.
REQ-002 SHALL have parameter LINE_BYTES, default 64, byte address stride between consecutive lines.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req  in  1  instruction-cache line read request, level, held until ic_done.
- ic_addr  in  32  instruction line address.
- ic_done  out  1  one-cycle pulse, line_data valid.
- dc_req  in  1  data-cache request, level, held until dc_done.
- dc_we  in  1  1 = write-back, 0 = fill.
- dc_addr  in  32  data line address.
- dc_wdata  in  512  write-back line.
- dc_done  out  1  one-cycle pulse, fill data valid or write accepted.
- ac_req  in  1  accelerator burst request, level, held until ac_done.
- ac_we  in  1  1 = burst write, 0 = burst read.
- ac_base  in  32  burst start address.
- ac_wdata  in  512  current write line from accelerator buffer.
- ac_wpop  out  1  pulse, accelerator advances ac_wdata next cycle.
- ac_rvld  out  1  pulse, line_data holds next burst read line.
- ac_done  out  1  pulse after final burst line.
- line_data  out  512  registered read data.
- op  out  2  host command: 00 idle, 01 read, 11 write.
- io_addr  out  32  host line address.
- common_data_bus_out  out  512  host write data.
- common_data_bus_in  in  512  host read data, valid with tx_done.
- tx_done  in  1  host transfer-complete pulse.
- rd_valid  in  1  host read-commit pulse, follows tx_done.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 SHALL implement states IDLE, IC_RD, DC_RD, DC_WR, AC_RD, AC_WR, RD_WAIT, WR_GAP.
REQ-005 SHALL register all outputs.
REQ-006 SHALL grant only in IDLE, fixed priority dc > ic > ac, and SHALL NOT preempt a grant.
REQ-007 SHALL enter the granted state the cycle after the request is sampled and SHALL drive op/io_addr on that cycle's edge.
REQ-008 SHALL drive op=01 in IC_RD/DC_RD/AC_RD, op=11 in DC_WR/AC_WR, and op=00 elsewhere.
REQ-009 SHALL force io_addr[5:0]=0 in every state.
REQ-010 Read states SHALL capture common_data_bus_in into line_data on tx_done and move to RD_WAIT.
REQ-011 RD_WAIT SHALL wait for rd_valid, then pulse ic_done, dc_done or ac_rvld for the owning requester.
REQ-012 In a read state, rd_valid without tx_done SHALL be ignored; tx_done and rd_valid in the same cycle SHALL act on tx_done only.
REQ-013 DC_WR SHALL latch dc_wdata onto common_data_bus_out at grant.
REQ-014 AC_WR SHALL present ac_wdata on common_data_bus_out.
REQ-015 On tx_done in a write state, the block SHALL pulse dc_done (DC_WR) or ac_wpop (AC_WR).
REQ-016 AC_WR SHALL go to WR_GAP (op=00) for exactly one cycle before the next line.
REQ-017 A line counter SHALL select io_addr = ac_base + LINE_BYTES*count, mod 2^32; wrap-around SHALL be silent.
REQ-018 After line BURST_LINES-1 completes, the block SHALL pulse ac_done in the same cycle as the final ac_rvld or ac_wpop, clear the counter, and return to IDLE.
REQ-019 Otherwise, after each line the block SHALL increment the counter and return to AC_RD (after RD_WAIT) or AC_WR (after WR_GAP).
REQ-020 tx_done and rd_valid in IDLE or WR_GAP SHALL be ignored.
REQ-021 A request deasserted mid-transfer SHALL NOT abort the transfer.

Reset
REQ-022 rst SHALL immediately force state IDLE, counter 0, op=00, io_addr=0, common_data_bus_out=0, line_data=0, all pulses 0, busy=0.
REQ-023 rst mid-burst SHALL abandon the burst with no ac_done; the first grant after rst release SHALL restart the burst at count 0.

Verification
REQ-024 ic_req, ic_addr=0x0000_0000; tx_done with bus=0x..0F..00 pattern, then rd_valid -> op=01 until tx_done, ic_done one pulse, line_data equals bus.
REQ-025 dc_req and ic_req raised in the same cycle, dc_we=1, dc_addr=0x3000_0000 -> DC_WR first (op=11, io_addr 0x3000_0000), dc_done on tx_done, then IC_RD.
REQ-026 ac_req, ac_we=0, ac_base=0x1000_0000, 128 tx_done/rd_valid pairs -> io_addr steps by 0x40 to 0x1000_1FC0, 128 ac_rvld pulses, ac_done with the last.
REQ-027 ac_we=1 burst, tx_done pulsed every other cycle -> 128 ac_wpop pulses, op=00 in each gap cycle, ac_done once.
REQ-028 rst asserted at line 50 of a read burst -> all outputs zero immediately; the next ac_req restarts at ac_base.
REQ-029 rd_valid before tx_done, and tx_done in IDLE -> no state change, no done pulses.

Source files
------------

// File: rtl/host_mem_arbiter.sv
// host_mem_arbiter
// Shares one host memory port between three requesters:
// - an instruction cache (line reads)
// - a data cache (line fills and write-backs)
// - an accelerator (BURST_LINES-line read or write bursts)
// A requester is granted only from IDLE, with fixed priority dc > ic > ac.
// A grant runs to completion and is never preempted. Every output is registered.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   ic_req/ic_addr/ic_done    instruction line read
//   dc_req/dc_we/dc_addr/
//   dc_wdata/dc_done          data line fill (dc_we=0) or write-back (dc_we=1)
//   ac_req/ac_we/ac_base/
//   ac_wdata/ac_wpop/
//   ac_rvld/ac_done           accelerator burst, one line at a time
//   line_data                 last line read from the host
//   op/io_addr/
//   common_data_bus_out       host command (00 idle, 01 read, 11 write), address, write data
//   common_data_bus_in        host read data, valid with tx_done
//   tx_done/rd_valid          host transfer-complete and read-commit pulses
//   busy                      high whenever the arbiter is not IDLE
module host_mem_arbiter #(
   parameter int BURST_LINES = 128,
   parameter int LINE_BYTES  = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ic_req,
   input  logic [31:0]  ic_addr,
   output logic         ic_done,
   input  logic         dc_req,
   input  logic         dc_we,
   input  logic [31:0]  dc_addr,
   input  logic [511:0] dc_wdata,
   output logic         dc_done,
   input  logic         ac_req,
   input  logic         ac_we,
   input  logic [31:0]  ac_base,
   input  logic [511:0] ac_wdata,
   output logic         ac_wpop,
   output logic         ac_rvld,
   output logic         ac_done,
   output logic [511:0] line_data,
   output logic [1:0]   op,
   output logic [31:0]  io_addr,
   output logic [511:0] common_data_bus_out,
   input  logic [511:0] common_data_bus_in,
   input  logic         tx_done,
   input  logic         rd_valid,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IC_RD   = 3'd1,
      DC_RD   = 3'd2,
      DC_WR   = 3'd3,
      AC_RD   = 3'd4,
      AC_WR   = 3'd5,
      RD_WAIT = 3'd6,
      WR_GAP  = 3'd7
   } state_t;

   // Remembers who owns a read while RD_WAIT waits for the commit pulse.
   typedef enum logic [1:0] {
      OWN_IC = 2'd0,
      OWN_DC = 2'd1,
      OWN_AC = 2'd2
   } owner_t;

   localparam int            CW        = (BURST_LINES > 1) ? $clog2(BURST_LINES) : 1;
   localparam logic [CW-1:0] LAST_LINE = CW'(BURST_LINES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [1:0]    OP_IDLE   = 2'b00;
   localparam logic [1:0]    OP_RD     = 2'b01;
   localparam logic [1:0]    OP_WR     = 2'b11;
   // Host addresses are whole 64-byte lines; the low six bits are always zero.
   localparam logic [31:0]   ADDR_MASK = 32'hFFFF_FFC0;

   state_t        state_r;
   owner_t        owner_r;
   logic [CW-1:0] count_r;
   logic [31:0]   base_r;

   // Address of burst line idx; the 32-bit sum wraps silently.
   function automatic logic [31:0] burst_addr(input logic [31:0] base, input logic [CW-1:0] idx);
      logic [31:0] offs;
      offs = 32'(LINE_BYTES) * 32'(idx);
      return (base + offs) & ADDR_MASK;
   endfunction

   // Arbitration FSM with all outputs registered; completion pulses default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r             <= IDLE;
         owner_r             <= OWN_IC;
         count_r             <= '0;
         base_r              <= 32'h0000_0000;
         op                  <= OP_IDLE;
         io_addr             <= 32'h0000_0000;
         common_data_bus_out <= '0;
         line_data           <= '0;
         ic_done             <= 1'b0;
         dc_done             <= 1'b0;
         ac_wpop             <= 1'b0;
         ac_rvld             <= 1'b0;
         ac_done             <= 1'b0;
         busy                <= 1'b0;
      end else begin
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         ac_wpop <= 1'b0;
         ac_rvld <= 1'b0;
         ac_done <= 1'b0;
         case (state_r)
            IDLE: begin
               op   <= OP_IDLE;
               busy <= 1'b0;
               if (dc_req) begin
                  owner_r <= OWN_DC;
                  io_addr <= dc_addr & ADDR_MASK;
                  busy    <= 1'b1;
                  if (dc_we) begin
                     state_r             <= DC_WR;
                     op                  <= OP_WR;
                     common_data_bus_out <= dc_wdata;
                  end else begin
                     state_r <= DC_RD;
                     op      <= OP_RD;
                  end
               end else if (ic_req) begin
                  owner_r <= OWN_IC;
                  io_addr <= ic_addr & ADDR_MASK;
                  busy    <= 1'b1;
                  state_r <= IC_RD;
                  op      <= OP_RD;
               end else if (ac_req) begin
                  // Base is latched so the burst address walk is immune to ac_base changes.
                  owner_r <= OWN_AC;
                  base_r  <= ac_base;
                  io_addr <= burst_addr(ac_base, count_r);
                  busy    <= 1'b1;
                  if (ac_we) begin
                     state_r             <= AC_WR;
                     op                  <= OP_WR;
                     common_data_bus_out <= ac_wdata;
                  end else begin
                     state_r <= AC_RD;
                     op      <= OP_RD;
                  end
               end
            end
            IC_RD, DC_RD, AC_RD: begin
               // rd_valid is only meaningful after tx_done, so it is ignored here.
               if (tx_done) begin
                  line_data <= common_data_bus_in;
                  op        <= OP_IDLE;
                  state_r   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (rd_valid) begin
                  case (owner_r)
                     OWN_IC: begin
                        ic_done <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                     end
                     OWN_DC: begin
                        dc_done <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                     end
                     OWN_AC: begin
                        ac_rvld <= 1'b1;
                        if (count_r == LAST_LINE) begin
                           ac_done <= 1'b1;
                           count_r <= '0;
                           busy    <= 1'b0;
                           state_r <= IDLE;
                        end else begin
                           count_r <= count_r + CNT_ONE;
                           io_addr <= burst_addr(base_r, count_r + CNT_ONE);
                           op      <= OP_RD;
                           state_r <= AC_RD;
                        end
                     end
                     default: begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                     end
                  endcase
               end
            end
            DC_WR: begin
               if (tx_done) begin
                  dc_done <= 1'b1;
                  op      <= OP_IDLE;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            AC_WR: begin
               // The accelerator line is presented continuously while the write is open.
               common_data_bus_out <= ac_wdata;
               if (tx_done) begin
                  ac_wpop <= 1'b1;
                  op      <= OP_IDLE;
                  if (count_r == LAST_LINE) begin
                     ac_done <= 1'b1;
                     count_r <= '0;
                     busy    <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     count_r <= count_r + CNT_ONE;
                     state_r <= WR_GAP;
                  end
               end
            end
            WR_GAP: begin
               // One idle-command cycle lets the accelerator advance to its next line.
               common_data_bus_out <= ac_wdata;
               io_addr             <= burst_addr(base_r, count_r);
               op                  <= OP_WR;
               state_r             <= AC_WR;
            end
            default: begin
               op      <= OP_IDLE;
               count_r <= '0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_host_mem_arbiter.sv
// Scoreboard bench for host_mem_arbiter.
// The stimulus side pushes the expected host commands and completion pulses of each round.
// Ordering follows dc > ic > ac, and an accelerator burst steps the address by one line per beat.
// A host model answers commands and checks them.
// A monitor pops and compares every completion pulse the DUT shows.
module tb_host_mem_arbiter;
   localparam int          BURST = 128;
   localparam int          LB    = 64;
   localparam logic [31:0] MASK  = 32'hFFFF_FFC0;

   logic         clk = 1'b0;
   logic         rst;
   logic         ic_req, dc_req, dc_we, ac_req, ac_we;
   logic [31:0]  ic_addr, dc_addr, ac_base;
   logic [511:0] dc_wdata, ac_wdata;
   logic         ic_done, dc_done, ac_wpop, ac_rvld, ac_done, busy;
   logic [511:0] line_data, common_data_bus_out, common_data_bus_in;
   logic [1:0]   op;
   logic [31:0]  io_addr;
   logic         tx_done, rd_valid;

   host_mem_arbiter #(.BURST_LINES(BURST), .LINE_BYTES(LB)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_done(dc_done),
      .ac_req(ac_req), .ac_we(ac_we), .ac_base(ac_base), .ac_wdata(ac_wdata),
      .ac_wpop(ac_wpop), .ac_rvld(ac_rvld), .ac_done(ac_done),
      .line_data(line_data), .op(op), .io_addr(io_addr),
      .common_data_bus_out(common_data_bus_out), .common_data_bus_in(common_data_bus_in),
      .tx_done(tx_done), .rd_valid(rd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] op; logic [31:0] addr; logic [511:0] data; } cmd_t;
   // pulses = {ic_done, dc_done, ac_rvld, ac_wpop, ac_done}
   typedef struct packed { logic [4:0] pulses; logic is_read; } rsp_t;

   cmd_t         cmd_q[$];
   rsp_t         rsp_q[$];
   logic [511:0] rdata_q[$];
   logic [511:0] abuf [BURST];
   logic [6:0]   aidx = 7'd0;
   int           checks = 0;
   int           passed = 0;
   bit           host_fast = 1'b0, stray_en = 1'b0, pat_mode = 1'b0, drop_en = 1'b0;
   bit           ic_p, dc_p, ac_p, ac_started;
   bit           do_ic, do_dc, do_ac;
   int           rvld_cnt;

   assign ac_wdata = abuf[aidx];

   function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic void fail_now(string msg);
      checks++;
      $display("FAIL %s", msg);
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Host model: answers each command, checks it against the expected command queue.
   initial begin : host
      int   hph, ph0, hdly, rdly;
      cmd_t hc;
      hph = 0; hdly = 0; rdly = 0; hc = '0;
      tx_done = 1'b0; rd_valid = 1'b0; common_data_bus_in = '0;
      forever begin
         @(negedge clk);
         tx_done  = 1'b0;
         rd_valid = 1'b0;
         ph0 = hph;
         if (rst) begin
            hph = 0;
         end else if (ph0 == 2) begin
            if (rdly == 0) begin rd_valid = 1'b1; hph = 0; end
            else rdly--;
         end else if (ph0 == 0) begin
            if (op != 2'b00) begin
               if (cmd_q.size() == 0) begin
                  fail_now($sformatf("unexpected_cmd: got op=%0b addr=%0h required none", op, io_addr));
                  hc = {op, io_addr, 512'd0};
               end else begin
                  hc = cmd_q.pop_front();
                  check("host_op", 512'(op), 512'(hc.op));
                  check("host_addr", 512'(io_addr), 512'(hc.addr));
               end
               hdly = host_fast ? 0 : int'($urandom_range(0, 2));
               hph  = 1;
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
               // Idle or write-gap cycle: these pulses must be ignored.
               tx_done  = 1'b1;
               rd_valid = 1'($urandom_range(0, 1));
               common_data_bus_in = rand512();
            end
         end
         if (!rst && hph == 1 && ph0 != 2) begin
            if (hdly == 0) begin
               tx_done = 1'b1;
               if (hc.op == 2'b11) begin
                  check("wr_data", common_data_bus_out, hc.data);
                  hph = 0;
               end else begin
                  common_data_bus_in = pat_mode ? {32{16'h0F00}} : rand512();
                  rdata_q.push_back(common_data_bus_in);
                  rd_valid = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                  rdly = host_fast ? 0 : int'($urandom_range(0, 2));
                  hph  = 2;
               end
            end else begin
               hdly--;
               if (hc.op == 2'b01 && stray_en && $urandom_range(0, 1) == 1) rd_valid = 1'b1;
            end
         end
      end
   end

   // Monitor: every completion pulse must match the next expected response.
   initial begin : monitor
      rsp_t       r;
      logic [4:0] p;
      forever begin
         @(negedge clk);
         p = {ic_done, dc_done, ac_rvld, ac_wpop, ac_done};
         if (!rst && p != 5'b00000) begin
            if (rsp_q.size() == 0) begin
               fail_now($sformatf("unexpected_pulse: got %05b required none", p));
            end else begin
               r = rsp_q.pop_front();
               check("done_pulses", 512'(p), 512'(r.pulses));
               if (r.is_read) begin
                  if (rdata_q.size() == 0) fail_now("line_data: got read pulse required host data first");
                  else check("line_data", line_data, rdata_q.pop_front());
               end
            end
            if (ac_wpop && !ac_done) check("gap_op", 512'(op), 512'(2'b00));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (ic_done) begin ic_p = 1'b0; ic_req = 1'b0; end
      if (dc_done) begin dc_p = 1'b0; dc_req = 1'b0; end
      if (ac_done) begin ac_p = 1'b0; ac_req = 1'b0; end
      if (ac_wpop) aidx = aidx + 7'd1;
      if (ac_rvld) rvld_cnt++;
      if (ac_rvld || ac_wpop) ac_started = 1'b1;
      // Data-cache write data must already be latched once the grant is taken.
      if (busy && dc_p) dc_wdata = rand512();
      // Dropping a request mid-burst must not abort the burst.
      if (drop_en && ac_started && ac_p && $urandom_range(0, 63) == 0) ac_req = 1'b0;
   endtask

   task automatic do_reset(input bit check_zero);
      #2 rst = 1'b1;
      #1;
      if (check_zero) begin
         check("rst_op", 512'(op), 512'(2'b00));
         check("rst_io_addr", 512'(io_addr), 512'(32'h0));
         check("rst_bus_out", common_data_bus_out, 512'd0);
         check("rst_line_data", line_data, 512'd0);
         check("rst_pulses", 512'({ic_done, dc_done, ac_rvld, ac_wpop, ac_done, busy}), 512'(6'd0));
      end
      cmd_q.delete(); rsp_q.delete(); rdata_q.delete();
      ic_req = 1'b0; dc_req = 1'b0; ac_req = 1'b0;
      ic_p = 1'b0; dc_p = 1'b0; ac_p = 1'b0;
      tick(); tick();
      aidx = 7'd0;
      #2 rst = 1'b0;
   endtask

   // Reference model for one round: dc first, then ic, then the full accelerator burst.
   task automatic run_round(input int rst_at);
      cmd_t c;
      rsp_t r;
      int   cyc;
      for (int k = 0; k < BURST; k++) abuf[k] = rand512();
      aidx = 7'd0; rvld_cnt = 0; ac_started = 1'b0;
      if (do_dc) begin
         c = {dc_we ? 2'b11 : 2'b01, dc_addr & MASK, dc_wdata};
         cmd_q.push_back(c);
         r = {5'b01000, ~dc_we};
         rsp_q.push_back(r);
      end
      if (do_ic) begin
         c = {2'b01, ic_addr & MASK, 512'd0};
         cmd_q.push_back(c);
         r = {5'b10000, 1'b1};
         rsp_q.push_back(r);
      end
      if (do_ac) begin
         for (int k = 0; k < BURST; k++) begin
            c = {ac_we ? 2'b11 : 2'b01, (ac_base + 32'(LB * k)) & MASK, abuf[k]};
            cmd_q.push_back(c);
            r.pulses = (ac_we ? 5'b00010 : 5'b00100) | ((k == BURST - 1) ? 5'b00001 : 5'b00000);
            r.is_read = ~ac_we;
            rsp_q.push_back(r);
         end
      end
      dc_req = do_dc; ic_req = do_ic; ac_req = do_ac;
      dc_p = do_dc; ic_p = do_ic; ac_p = do_ac;
      cyc = 0;
      while ((dc_p || ic_p || ac_p) && cyc < 4000) begin
         tick();
         cyc++;
         if (rst_at >= 0 && rvld_cnt == rst_at) begin
            do_reset(1'b1);
            return;
         end
      end
      if (dc_p || ic_p || ac_p) begin
         fail_now($sformatf("round_timeout: got pending dc=%0d ic=%0d ac=%0d required none", dc_p, ic_p, ac_p));
         do_reset(1'b0);
      end else begin
         tick(); tick();
         check("idle_busy", 512'(busy), 512'(1'b0));
         check("cmd_q_empty", 512'(cmd_q.size()), 512'(0));
         check("rsp_q_empty", 512'(rsp_q.size()), 512'(0));
      end
   endtask

   initial begin : main
      logic [2:0] s;
      rst = 1'b1;
      ic_req = 1'b0; dc_req = 1'b0; ac_req = 1'b0; dc_we = 1'b0; ac_we = 1'b0;
      ic_addr = 32'h0; dc_addr = 32'h0; ac_base = 32'h0; dc_wdata = '0;
      for (int k = 0; k < BURST; k++) abuf[k] = '0;
      repeat (3) @(negedge clk);
      check("init_op", 512'(op), 512'(2'b00));
      check("init_io_addr", 512'(io_addr), 512'(32'h0));
      check("init_outs", 512'({ic_done, dc_done, ac_rvld, ac_wpop, ac_done, busy}), 512'(6'd0));
      check("init_line_data", line_data, 512'd0);
      #2 rst = 1'b0;

      // Stray host pulses while idle: nothing may happen.
      stray_en = 1'b1;
      repeat (20) tick();
      check("stray_idle_busy", 512'(busy), 512'(1'b0));
      check("stray_idle_op", 512'(op), 512'(2'b00));

      // Instruction read at address 0 with a fixed bus pattern.
      pat_mode = 1'b1; do_dc = 1'b0; do_ic = 1'b1; do_ac = 1'b0; ic_addr = 32'h0000_0000;
      run_round(-1);
      pat_mode = 1'b0;

      // Simultaneous dc write-back and ic read: dc wins.
      do_dc = 1'b1; dc_we = 1'b1; dc_addr = 32'h3000_0000; dc_wdata = rand512();
      do_ic = 1'b1; ic_addr = 32'h0000_1240;
      run_round(-1);

      // Full accelerator read burst from 0x1000_0000.
      do_dc = 1'b0; do_ic = 1'b0; do_ac = 1'b1; ac_we = 1'b0; ac_base = 32'h1000_0000;
      run_round(-1);

      // Accelerator write burst answered every other cycle.
      host_fast = 1'b1; ac_we = 1'b1; ac_base = 32'h2000_0000;
      run_round(-1);
      host_fast = 1'b0;

      // Reset at line 50 of a read burst, then the burst restarts at its base.
      ac_we = 1'b0; ac_base = 32'h4000_0000;
      run_round(50);
      run_round(-1);

      // Randomised rounds, including address wrap and mid-burst request drops.
      for (int n = 0; n < 10; n++) begin
         s = 3'($urandom_range(1, 7));
         do_dc = s[0]; do_ic = s[1]; do_ac = s[2];
         dc_we = 1'($urandom_range(0, 1)); ac_we = 1'($urandom_range(0, 1));
         dc_addr = $urandom; ic_addr = $urandom; dc_wdata = rand512();
         ac_base = ($urandom_range(0, 2) == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 63))) : $urandom;
         host_fast = 1'($urandom_range(0, 1));
         stray_en  = 1'($urandom_range(0, 1));
         drop_en   = 1'($urandom_range(0, 1));
         run_round(-1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
